// File: rtl/vlc_axil_pkg.sv
// rtl/vlc_axil_pkg.sv - register map, response codes and channel states for the VLC RX AXI-Lite FIFO
package vlc_axil_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_DROPCNT = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 16;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    function automatic logic [31:0] status_word(input logic [15:0] count, input logic ovf,
                                                input logic full, input logic empty);
        logic [31:0] w;
        w = '0;
        w[STAT_COUNT_LSB +: 16] = count;
        w[STAT_OVF_BIT]         = ovf;
        w[STAT_FULL_BIT]        = full;
        w[STAT_EMPTY_BIT]       = empty;
        return w;
    endfunction

endpackage

// File: rtl/vlc_sync_fifo.sv
// rtl/vlc_sync_fifo.sv - single-clock word FIFO with push, pop, flush and occupancy count
module vlc_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/vlc_rx_axil_fifo.sv
// rtl/vlc_rx_axil_fifo.sv - AXI-Lite responder draining the VLC RX word FIFO; option macro VLC_RX_DROP_CNT_EN
module vlc_rx_axil_fifo
    import vlc_axil_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              buff_full,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic [31:0]      w_head;
    logic             w_push;
    logic             w_drop;
    logic             w_flush;
    logic             w_clr_ovf;
    logic             w_ctrl_wr;
    logic [1:0]       w_wr_sel;
    logic [1:0]       w_rd_sel;
    logic             w_wr_hs;
    logic             w_rd_hs;
    logic             w_rd_pop;
    logic [31:0]      w_rd_data;
    logic [1:0]       w_rd_resp;
    wr_state_e        r_wr_state;
    wr_state_e        w_wr_state_nxt;
    rd_state_e        r_rd_state;
    rd_state_e        w_rd_state_nxt;
    logic             r_ovf;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic [1:0]       r_bresp;
    logic             w_unused;

    assign w_unused = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                        s_axi_wstrb, s_axi_wdata};

    assign in_ready  = !w_full;
    assign buff_full = w_full;
    assign w_push    = in_valid && !w_full;
    assign w_drop    = in_valid && w_full;

    assign w_wr_sel  = s_axi_awaddr[3:2];
    assign w_rd_sel  = s_axi_araddr[3:2];
    assign w_ctrl_wr = w_wr_hs && (w_wr_sel == REG_CTRL) && s_axi_wstrb[0];
    assign w_flush   = w_ctrl_wr && s_axi_wdata[CTRL_FLUSH_BIT];
    assign w_clr_ovf = w_ctrl_wr && s_axi_wdata[CTRL_CLR_OVF_BIT];

    vlc_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_rd_pop),
        .i_flush (w_flush),
        .i_wdata (in_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A new drop wins over a same-cycle clear so no overflow event is lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_ovf <= 1'b0;
        else         r_ovf <= (r_ovf && !w_clr_ovf) || w_drop;
    end

`ifdef VLC_RX_DROP_CNT_EN
    logic [31:0] r_drop_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                        r_drop_cnt <= '0;
        else if (w_flush || w_clr_ovf)                      r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF))   r_drop_cnt <= r_drop_cnt + 32'd1;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_wr_state <= WR_IDLE;
        else         r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_hs        = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_wr_hs        = 1'b1;
                    w_wr_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) w_wr_state_nxt = WR_IDLE;
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    assign s_axi_awready = w_wr_hs;
    assign s_axi_wready  = w_wr_hs;
    assign s_axi_bvalid  = (r_wr_state == WR_RESP);
    assign s_axi_bresp   = r_bresp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      r_bresp <= RESP_OKAY;
        else if (w_wr_hs) r_bresp <= (w_wr_sel == REG_CTRL) ? RESP_OKAY : RESP_SLVERR;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rd_state <= RD_IDLE;
        else         r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_hs        = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (s_axi_arvalid) begin
                    w_rd_hs        = 1'b1;
                    w_rd_state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_axi_rready) w_rd_state_nxt = RD_IDLE;
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // The DATA pop happens on the acceptance edge, together with latching rdata.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        w_rd_pop  = 1'b0;
        case (w_rd_sel)
            REG_DATA: begin
                if (!w_empty) begin
                    w_rd_data = w_head;
                    w_rd_resp = RESP_OKAY;
                    w_rd_pop  = w_rd_hs;
                end
            end
            REG_STATUS: begin
                w_rd_data = status_word(16'(w_count), r_ovf, w_full, w_empty);
                w_rd_resp = RESP_OKAY;
            end
            REG_DROPCNT: begin
`ifdef VLC_RX_DROP_CNT_EN
                w_rd_data = r_drop_cnt;
                w_rd_resp = RESP_OKAY;
`endif
            end
            default: ;
        endcase
    end

    assign s_axi_arready = w_rd_hs;
    assign s_axi_rvalid  = (r_rd_state == RD_RESP);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_rd_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

endmodule
